// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame length and parity helper.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } tx_state_e;

    // Odd parity bit for a data byte: data plus this bit always has an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return 1'b1 ^ (^data);
    endfunction

endpackage

// File: rtl/ps2_send_if.sv
// Byte handshake and open-drain PS/2 line signals of the device-side transmitter.
interface ps2_send_if;

    logic [7:0] word;
    logic       start;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       clk_o;
    logic       dat_o;
    logic       clk_i;

    modport master (
        output word, start, clk_i,
        input  busy, done, aborted, clk_o, dat_o
    );

    modport slave (
        input  word, start, clk_i,
        output busy, done, aborted, clk_o, dat_o
    );

endinterface

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for the sensed PS/2 bus clock; resets to the idle-high level.
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/ps2_send.sv
// Device-side PS/2 transmitter: sends one byte as an 11-bit frame, driving both bus lines
// and aborting if the host inhibits the clock before the stop bit.
module ps2_send
    import ps2_pkg::*;
#(
    parameter int unsigned HALF = 4,
    parameter int unsigned GAP  = 8
) (
    input  logic      sysclk,
    input  logic      reset,
    ps2_send_if.slave bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned SHR_W = FRAME_BITS - 1;

    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    // First phase cycle at which the synchronised clock reflects our own release.
    localparam logic [CNT_W-1:0] INHIBIT_FROM = CNT_W'(2);
    localparam logic [IDX_W-1:0] STOP_IDX     = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] ABORT_MAX    = IDX_W'(FRAME_BITS - 2);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [SHR_W-1:0] shr_q,   shr_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             abrt_q,  abrt_d;
    logic             clk_q,   clk_d;
    logic             dat_q,   dat_d;
    logic             clk_sync;

    ps2_sync u_sync (
        .clk (sysclk),
        .rst (reset),
        .d_i (bus.clk_i),
        .q_o (clk_sync)
    );

    // State, counters and registered line drives; reset releases both lines at once.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shr_q   <= shr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
        end
    end

    // Next-state logic: bit-cell phase sequencing, inhibit abort and completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shr_d   = shr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        abrt_d  = 1'b0;
        clk_d   = clk_q;
        dat_d   = dat_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.start && !busy_q && clk_sync) begin
                    state_d = ST_HIGH;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    dat_d   = 1'b0;
                    // Remaining bits after the start bit, shifted out LSB first.
                    shr_d   = {1'b1, odd_parity(bus.word), bus.word};
                end
            end

            ST_HIGH: begin
                if (cnt_q >= INHIBIT_FROM && !clk_sync && clk_q && idx_q <= ABORT_MAX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    abrt_d  = 1'b1;
                    clk_d   = 1'b1;
                    dat_d   = 1'b1;
                end else if (cnt_q == HALF_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end
            end

            ST_LOW: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    clk_d = 1'b1;
                    if (idx_q == STOP_IDX) begin
                        state_d = ST_GAP;
                        dat_d   = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                        idx_d   = idx_q + IDX_W'(1);
                        dat_d   = shr_q[0];
                        shr_d   = {1'b1, shr_q[SHR_W-1:1]};
                    end
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = abrt_q;
    assign bus.clk_o   = clk_q;
    assign bus.dat_o   = dat_q;

endmodule

// File: tb/tb_ps2_send.sv
// Randomised bench for ps2_send with a host loopback on the bus clock and a frame-level model.
module tb_ps2_send;

    localparam int HALF = 4;
    localparam int GAP  = 8;
    localparam int LAT  = 1 + 22 * HALF + GAP;

    logic sysclk    = 1'b0;
    logic reset     = 1'b1;
    logic host_hold = 1'b0;

    ps2_send_if bus ();

    // Open-drain bus clock: low if either side pulls it.
    assign bus.clk_i = bus.clk_o & ~host_hold;

    always #5 sysclk = ~sysclk;

    ps2_send #(.HALF(HALF), .GAP(GAP)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    int n_checks    = 0;
    int errors      = 0;
    int done_cnt    = 0;
    int overlap_cnt = 0;
    logic cap_q[$];

    // Host-side sampling: data is read on each falling edge of the device clock.
    always @(negedge bus.clk_o) cap_q.push_back(bus.dat_o);

    always @(negedge sysclk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.done === 1'b1 && bus.aborted === 1'b1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected frame, bit i = i-th bit on the wire.
    function automatic logic [10:0] model_frame(input logic [7:0] w);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = (((w >> i) & 8'd1) != 0);
        f[9]  = ($countones(w) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic logic [10:0] captured(input int base);
        logic [10:0] f;
        for (int i = 0; i < 11; i++)
            f[i] = (base + i < cap_q.size()) ? cap_q[base + i] : 1'bx;
        return f;
    endfunction

    // Receiver acceptance: start low, stop high, odd parity over data and parity bit.
    function automatic logic rx_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ($countones(f[9:1]) % 2 == 1);
    endfunction

    task automatic start_frame(input logic [7:0] w, output int base);
        @(negedge sysclk);
        base      = cap_q.size();
        bus.word  = w;
        bus.start = 1'b1;
        @(negedge sysclk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (bus.done !== 1'b1 && cyc < 400) begin
            @(negedge sysclk);
            cyc++;
        end
    endtask

    task automatic send_check(input logic [7:0] w, input string tag, output logic [10:0] fr);
        int base;
        int lat;
        start_frame(w, base);
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_dat_start"}, bus.dat_o, 0);
        bus.word = 8'($urandom);
        wait_done(1, lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_busy_end"}, bus.busy, 0);
        fr = captured(base);
        check({tag, "_frame"}, fr, model_frame(w));
    endtask

    initial begin
        logic [10:0] fr;
        logic [10:0] fr2;
        logic [7:0]  w;
        logic [7:0]  wb;
        int base;
        int base2;
        int lat;
        int k;
        int d0;
        bit busy_seen;

        bus.word  = 8'h00;
        bus.start = 1'b0;
        repeat (3) @(negedge sysclk);
        check("rst_clk_o", bus.clk_o, 1);
        check("rst_dat_o", bus.dat_o, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_aborted", bus.aborted, 0);
        reset = 1'b0;
        repeat (3) @(negedge sysclk);

        // Directed byte with known wire pattern.
        send_check(8'h1C, "d1c", fr);
        check("d1c_const", fr, 11'b100_0011_1000);

        // Random bytes with random idle spacing.
        for (int n = 0; n < 6; n++) begin
            w = 8'($urandom);
            send_check(w, $sformatf("rnd%0d", n), fr);
            repeat ($urandom_range(0, 5)) @(negedge sysclk);
        end

        // Back-to-back 0x00 then 0xFF with start held high.
        @(negedge sysclk);
        base      = cap_q.size();
        bus.word  = 8'h00;
        bus.start = 1'b1;
        @(negedge sysclk);
        check("b2b_busy0", bus.busy, 1);
        wait_done(1, lat);
        check("b2b_lat0", lat, LAT);
        bus.word = 8'hFF;
        fr    = captured(base);
        base2 = cap_q.size();
        check("b2b_frame0", fr, model_frame(8'h00));
        check("b2b_rx0", rx_ok(fr), 1);
        check("b2b_par0", fr[9], 1);
        @(negedge sysclk);
        check("b2b_restart", bus.busy, 1);
        check("b2b_start_bit", bus.dat_o, 0);
        bus.start = 1'b0;
        wait_done(1, lat);
        check("b2b_lat1", lat, LAT);
        fr2 = captured(base2);
        check("b2b_frame1", fr2, model_frame(8'hFF));
        check("b2b_rx1", rx_ok(fr2), 1);
        check("b2b_par1", fr2[9], 1);
        check("b2b_data1", fr2[8:1], 8'hFF);

        // Host inhibit while idle holds off the request.
        repeat (3) @(negedge sysclk);
        host_hold = 1'b1;
        repeat (3) @(negedge sysclk);
        base      = cap_q.size();
        bus.word  = 8'h5A;
        bus.start = 1'b1;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge sysclk);
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
        end
        check("inh_busy", busy_seen, 0);
        check("inh_edges", cap_q.size() - base, 0);
        check("inh_dat", bus.dat_o, 1);
        host_hold = 1'b0;
        k = 0;
        while (bus.busy !== 1'b1 && k < 20) begin
            @(negedge sysclk);
            k++;
        end
        check("inh_release_delay", k, 3);
        bus.start = 1'b0;
        bus.word  = 8'h00;
        wait_done(1, lat);
        check("inh_lat", lat, LAT);
        check("inh_frame", captured(base), model_frame(8'h5A));

        // Host inhibit during the high phase of bit index 4.
        repeat (4) @(negedge sysclk);
        w = 8'($urandom);
        start_frame(w, base);
        k = 0;
        while ((cap_q.size() - base) < 4 && k < 300) begin
            @(negedge sysclk);
            k++;
        end
        while (bus.clk_o !== 1'b1 && k < 300) begin
            @(negedge sysclk);
            k++;
        end
        check("ab_reach_bit4", (k < 300), 1);
        d0 = done_cnt;
        host_hold = 1'b1;
        k = 0;
        while (bus.aborted !== 1'b1 && k < 20) begin
            @(negedge sysclk);
            k++;
        end
        check("ab_pulse", bus.aborted, 1);
        check("ab_busy", bus.busy, 0);
        check("ab_clk_rel", bus.clk_o, 1);
        check("ab_dat_rel", bus.dat_o, 1);
        check("ab_bits_sent", captured(base) & 11'h00F, model_frame(w) & 11'h00F);
        @(negedge sysclk);
        check("ab_pulse_len", bus.aborted, 0);
        host_hold = 1'b0;
        repeat (150) @(negedge sysclk);
        check("ab_no_done", done_cnt - d0, 0);
        check("ab_no_more_edges", cap_q.size() - base, 4);
        check("ab_idle_busy", bus.busy, 0);

        // Asynchronous reset during the low phase of bit 6.
        w = 8'($urandom);
        start_frame(w, base);
        k = 0;
        while ((cap_q.size() - base) < 7 && k < 300) begin
            @(negedge sysclk);
            k++;
        end
        check("rst_reach_bit6", bus.clk_o, 0);
        #2 reset = 1'b1;
        #1;
        check("rst_async_clk", bus.clk_o, 1);
        check("rst_async_dat", bus.dat_o, 1);
        check("rst_async_busy", bus.busy, 0);
        @(negedge sysclk);
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        send_check(8'($urandom), "post_rst", fr);

        // New request mid-frame is ignored; the latched byte is sent.
        w  = 8'($urandom);
        wb = ~w;
        start_frame(w, base);
        k = 0;
        while ((cap_q.size() - base) < 3 && k < 300) begin
            @(negedge sysclk);
            k++;
        end
        bus.word  = wb;
        bus.start = 1'b1;
        repeat (10) @(negedge sysclk);
        bus.start = 1'b0;
        check("mid_busy", bus.busy, 1);
        wait_done(0, lat);
        check("mid_done", bus.done, 1);
        check("mid_frame", captured(base), model_frame(w));
        repeat (5) @(negedge sysclk);
        check("mid_no_requeue", bus.busy, 0);

        check("done_abort_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
